// File: rtl/cnn_header_loader.sv
// Loads the CNN configuration header into the byte-wide parameter RAM, then
// serialises streamed payload words (MSB byte first) into the same RAM.
module cnn_header_loader #(
  parameter int DATA_W     = 16,
  parameter int RAM_DW     = 8,
  parameter int ADDR_W     = 16,
  parameter int MAX_LAYERS = 10
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      cnn,
  input  logic [ADDR_W-1:0]         img_base,
  input  logic [7:0]                filter_size,
  input  logic [7:0]                num_layers,
  input  logic [8*MAX_LAYERS-1:0]   n_filt,
  input  logic [8*MAX_LAYERS-1:0]   f_type,
  input  logic [8*(MAX_LAYERS-1)-1:0] n_dense,
  input  logic [8*(MAX_LAYERS-1)-1:0] n_wght,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [RAM_DW-1:0]         ram_din,
  output logic                      ram_we,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W-1:0]         words
);

  localparam int BPW   = DATA_W / RAM_DW;
  localparam int REM_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {IDLE, CALC, HDR, PAY, DONE} state_t;

  state_t                       state;
  logic [7:0]                   fs_r;
  logic [7:0]                   l_r;
  logic [8*MAX_LAYERS-1:0]      nf_r;
  logic [8*MAX_LAYERS-1:0]      ft_r;
  logic [8*(MAX_LAYERS-1)-1:0]  nd_r;
  logic [8*(MAX_LAYERS-1)-1:0]  nw_r;
  logic [15:0]                  acc;
  logic [7:0]                   calc_idx;
  logic [7:0]                   hdr_idx;
  logic [ADDR_W:0]              ptr;
  logic [DATA_W-1:0]            shreg;
  logic [REM_W-1:0]             rem;
  logic                         fin;

  logic [15:0]                  fo;
  logic [15:0]                  do_v;
  logic [15:0]                  term;
  logic [7:0]                   nf_end;
  logic [7:0]                   ft_end;
  logic [7:0]                   hdr_len;
  logic [7:0]                   rel;
  logic [7:0]                   hdr_byte;
  logic                         accept;
  logic                         pay_emit;
  logic [RAM_DW-1:0]            pay_byte;
  logic                         byte_last;
  logic                         word_final;

  assign fo      = 16'd4 + (16'(l_r) << 2);
  assign do_v    = fo + acc;
  assign nf_end  = 8'd6 + l_r;
  assign ft_end  = nf_end + l_r;
  assign hdr_len = 8'd4 + (l_r << 2);
  assign term    = 16'(32'(nf_r[{calc_idx, 3'b000} +: 8])
                       * (32'(fs_r) * 32'(fs_r) + 32'd1) * 32'(BPW));

  // Header layout: fs, L, FO, DO, per-layer filter counts, per-layer types,
  // then (dense, weight) pairs for each of the L-1 dense layers.
  always_comb begin
    hdr_byte = '0;
    rel      = '0;
    if (hdr_idx == 8'd0)      hdr_byte = fs_r;
    else if (hdr_idx == 8'd1) hdr_byte = l_r;
    else if (hdr_idx == 8'd2) hdr_byte = fo[15:8];
    else if (hdr_idx == 8'd3) hdr_byte = fo[7:0];
    else if (hdr_idx == 8'd4) hdr_byte = do_v[15:8];
    else if (hdr_idx == 8'd5) hdr_byte = do_v[7:0];
    else if (hdr_idx < nf_end) begin
      rel      = hdr_idx - 8'd6;
      hdr_byte = nf_r[{rel, 3'b000} +: 8];
    end else if (hdr_idx < ft_end) begin
      rel      = hdr_idx - nf_end;
      hdr_byte = ft_r[{rel, 3'b000} +: 8];
    end else begin
      rel      = hdr_idx - ft_end;
      hdr_byte = rel[0] ? nw_r[{rel[7:1], 3'b000} +: 8]
                        : nd_r[{rel[7:1], 3'b000} +: 8];
    end
  end

  always_comb begin
    accept     = (state == PAY) && s_valid && s_ready && (rem == '0);
    pay_emit   = accept || ((state == PAY) && (rem != '0));
    pay_byte   = accept ? s_data[DATA_W-1 -: RAM_DW] : shreg[DATA_W-1 -: RAM_DW];
    byte_last  = accept ? (BPW == 1) : (rem == REM_W'(1));
    word_final = accept ? s_last : fin;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      words    <= '0;
      fs_r     <= '0;
      l_r      <= '0;
      nf_r     <= '0;
      ft_r     <= '0;
      nd_r     <= '0;
      nw_r     <= '0;
      acc      <= '0;
      calc_idx <= '0;
      hdr_idx  <= '0;
      ptr      <= '0;
      shreg    <= '0;
      rem      <= '0;
      fin      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            fs_r     <= filter_size;
            l_r      <= num_layers;
            nf_r     <= n_filt;
            ft_r     <= f_type;
            nd_r     <= n_dense;
            nw_r     <= n_wght;
            err      <= 1'b0;
            words    <= '0;
            acc      <= '0;
            calc_idx <= '0;
            hdr_idx  <= '0;
            rem      <= '0;
            fin      <= 1'b0;
            if (cnn) begin
              if ((num_layers == 8'd0) || (num_layers > 8'(MAX_LAYERS))) begin
                err   <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                busy  <= 1'b1;
                state <= CALC;
              end
            end else begin
              busy    <= 1'b1;
              s_ready <= 1'b1;
              ptr     <= {1'b0, img_base};
              state   <= PAY;
            end
          end
        end

        // One layer per cycle; the final cycle also issues header byte 0.
        CALC: begin
          acc      <= acc + term;
          calc_idx <= calc_idx + 8'd1;
          if (calc_idx == l_r - 8'd1) begin
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= RAM_DW'(hdr_byte);
            hdr_idx  <= 8'd1;
            state    <= HDR;
          end
        end

        HDR: begin
          if (hdr_idx == hdr_len) begin
            s_ready <= 1'b1;
            ptr     <= (ADDR_W+1)'(fo);
            state   <= PAY;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= ADDR_W'(hdr_idx);
            ram_din  <= RAM_DW'(hdr_byte);
            hdr_idx  <= hdr_idx + 8'd1;
          end
        end

        // ptr carries one extra bit so a write past the top address is caught
        // instead of wrapping to zero.
        PAY: begin
          if (fin && (rem == '0)) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (pay_emit) begin
            if (accept) begin
              words <= words + 1'b1;
              shreg <= s_data << RAM_DW;
              fin   <= s_last;
              rem   <= REM_W'(BPW - 1);
            end else begin
              shreg <= shreg << RAM_DW;
              rem   <= rem - 1'b1;
            end
            if (ptr[ADDR_W]) begin
              err     <= 1'b1;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              rem     <= '0;
              state   <= DONE;
            end else begin
              ram_we   <= 1'b1;
              ram_addr <= ptr[ADDR_W-1:0];
              ram_din  <= pay_byte;
              ptr      <= ptr + 1'b1;
              s_ready  <= byte_last && !word_final;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
